cache_line: RTL



---
 rtl/cache_pkg.sv | 11 +
 rtl/cache_line_if.sv | 45 ++++
 rtl/cache_line_store.sv | 48 ++++
 rtl/cache_line.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared constants for the TTCache data array: FSM state encoding and default geometry.
// Imported by cache_line, its word store and the set/way wrapper.
package cache_pkg;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_FILL = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam int DATA_W_DEF   = 16;
   localparam int TAG_W_DEF    = 8;
   localparam int OFFSET_W_DEF = 2;
endpackage

// File: rtl/cache_line_if.sv
// Request/response and fill bundle between lookup logic (master) and one cache line (slave).
// parity_err exists only when CACHE_LINE_PARITY_EN is defined.
import cache_pkg::*;

interface cache_line_if #(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int TAG_W    = TAG_W_DEF,
   parameter int OFFSET_W = OFFSET_W_DEF
);
   logic                enable;
   logic                write;
   logic                fill;
   logic                flush;
   logic [TAG_W-1:0]    tag_in;
   logic [OFFSET_W-1:0] offset;
   logic [DATA_W-1:0]   data_in;
   logic                fill_valid;
   logic [DATA_W-1:0]   fill_data;
   logic [DATA_W-1:0]   data_out;
   logic                hit;
   logic                ack;
   logic                valid;
   logic                dirty;
   logic [TAG_W-1:0]    tag_out;
   logic                busy;
`ifdef CACHE_LINE_PARITY_EN
   logic                parity_err;
`endif

   modport master (
      output enable, write, fill, flush, tag_in, offset, data_in, fill_valid, fill_data,
      input  data_out, hit, ack, valid, dirty, tag_out, busy
`ifdef CACHE_LINE_PARITY_EN
      , input parity_err
`endif
   );

   modport slave (
      input  enable, write, fill, flush, tag_in, offset, data_in, fill_valid, fill_data,
      output data_out, hit, ack, valid, dirty, tag_out, busy
`ifdef CACHE_LINE_PARITY_EN
      , output parity_err
`endif
   );
endinterface

// File: rtl/cache_line_store.sv
// Word array of one line: single muxed write port, combinational read port.
// With CACHE_LINE_PARITY_EN each word carries an even-parity bit checked on read.
import cache_pkg::*;

module cache_line_store #(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int OFFSET_W = OFFSET_W_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                we,
   input  logic [OFFSET_W-1:0] waddr,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [OFFSET_W-1:0] raddr,
   output logic [DATA_W-1:0]   rdata
`ifdef CACHE_LINE_PARITY_EN
   ,
   output logic                rd_perr
`endif
);
   localparam int WORDS = 2**OFFSET_W;

   logic [DATA_W-1:0] mem [WORDS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < WORDS; i++) mem[i] <= '0;
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

`ifdef CACHE_LINE_PARITY_EN
   logic par_mem [WORDS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < WORDS; i++) par_mem[i] <= 1'b0;
      end else if (we) begin
         par_mem[waddr] <= ^wdata;
      end
   end

   assign rd_perr = (^mem[raddr]) ^ par_mem[raddr];
`endif
endmodule

// File: rtl/cache_line.sv
// One cache line: tag/valid/dirty, tag-compared read/write with 1-cycle ack, word-by-word fill.
// Fill stalls on fill_valid=0; flush wins over any request. Optional CACHE_LINE_PARITY_EN.
import cache_pkg::*;

module cache_line #(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int TAG_W    = TAG_W_DEF,
   parameter int OFFSET_W = OFFSET_W_DEF
) (
   input logic         clk,
   input logic         rst_n,
   cache_line_if.slave bus
);
   logic [1:0]          state;
   logic [OFFSET_W-1:0] cnt;
   logic [TAG_W-1:0]    tag_q;
   logic                valid_q;
   logic                dirty_q;
   logic                ack_q;
   logic                hit_q;
   logic [DATA_W-1:0]   dout_q;
   logic [DATA_W-1:0]   rd_data;

   logic                tag_match;
   logic                idle_req;
   logic                do_fill;
   logic                do_write;
   logic                do_read;
   logic                fill_beat;
   logic                we;
   logic [OFFSET_W-1:0] waddr;
   logic [DATA_W-1:0]   wdata;

   // Folding valid into the match guarantees no hit is ever reported on an invalid line.
   assign tag_match = valid_q && (bus.tag_in == tag_q);
   assign idle_req  = (state == ST_IDLE) && !bus.flush && bus.enable;
   assign do_fill   = idle_req && bus.fill;
   assign do_write  = idle_req && !bus.fill && bus.write;
   assign do_read   = idle_req && !bus.fill && !bus.write;
   assign fill_beat = (state == ST_FILL) && !bus.flush && bus.fill_valid;
   assign we        = fill_beat || (do_write && tag_match);
   assign waddr     = fill_beat ? cnt : bus.offset;
   assign wdata     = fill_beat ? bus.fill_data : bus.data_in;

`ifdef CACHE_LINE_PARITY_EN
   logic rd_perr;
   logic perr_q;
`endif

   cache_line_store #(
      .DATA_W   (DATA_W),
      .OFFSET_W (OFFSET_W)
   ) u_store (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (we),
      .waddr   (waddr),
      .wdata   (wdata),
      .raddr   (bus.offset),
      .rdata   (rd_data)
`ifdef CACHE_LINE_PARITY_EN
      ,
      .rd_perr (rd_perr)
`endif
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         tag_q   <= '0;
         valid_q <= 1'b0;
         dirty_q <= 1'b0;
         ack_q   <= 1'b0;
         hit_q   <= 1'b0;
         dout_q  <= '0;
`ifdef CACHE_LINE_PARITY_EN
         perr_q  <= 1'b0;
`endif
      end else begin
         ack_q  <= 1'b0;
         hit_q  <= 1'b0;
         dout_q <= '0;
`ifdef CACHE_LINE_PARITY_EN
         perr_q <= 1'b0;
`endif
         case (state)
            ST_IDLE: begin
               if (bus.flush) begin
                  valid_q <= 1'b0;
                  dirty_q <= 1'b0;
                  ack_q   <= 1'b1;
               end else if (do_fill) begin
                  state   <= ST_FILL;
                  valid_q <= 1'b0;
                  dirty_q <= 1'b0;
                  tag_q   <= bus.tag_in;
                  cnt     <= '0;
               end else if (do_write) begin
                  ack_q <= 1'b1;
                  hit_q <= tag_match;
                  if (tag_match) dirty_q <= 1'b1;
               end else if (do_read) begin
                  ack_q <= 1'b1;
                  hit_q <= tag_match;
                  if (tag_match) dout_q <= rd_data;
`ifdef CACHE_LINE_PARITY_EN
                  perr_q <= tag_match && rd_perr;
`endif
               end
            end
            ST_FILL: begin
               if (bus.flush) begin
                  state   <= ST_IDLE;
                  cnt     <= '0;
                  valid_q <= 1'b0;
                  dirty_q <= 1'b0;
                  ack_q   <= 1'b1;
               end else if (fill_beat) begin
                  cnt <= cnt + 1'b1;
                  if (&cnt) begin
                     state   <= ST_DONE;
                     valid_q <= 1'b1;
                     dirty_q <= 1'b0;
                     ack_q   <= 1'b1;
                     hit_q   <= 1'b1;
                  end
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               if (bus.flush) begin
                  valid_q <= 1'b0;
                  dirty_q <= 1'b0;
                  ack_q   <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.data_out = dout_q;
   assign bus.hit      = hit_q;
   assign bus.ack      = ack_q;
   assign bus.valid    = valid_q;
   assign bus.dirty    = dirty_q;
   assign bus.tag_out  = tag_q;
   assign bus.busy     = (state == ST_FILL);
`ifdef CACHE_LINE_PARITY_EN
   assign bus.parity_err = perr_q;
`endif
endmodule
